seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial pattern detector; successor to the fixed 12-bit detector.
- Pattern, length, overlap mode and (optionally) don't-care mask are loaded by a config write.
- Accepts one bit per cycle under a valid qualifier.
- Outputs a one-cycle detect pulse and a saturating match counter; sits on serial/framing paths as a sync-word or flag detector.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (2..64)
CNT_W, 8, width of match counter
LEN_W, $clog2(MAX_LEN)+1, width of length field (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cfg_we_i  input  1  config write strobe, one cycle
cfg_pattern_i  input  MAX_LEN  pattern; bit [len-1] = oldest bit, bit 0 = newest bit
cfg_len_i  input  LEN_W  pattern length in bits
cfg_overlap_i  input  1  1 = overlapping matches allowed, 0 = non-overlapping
cfg_mask_i  input  MAX_LEN  per-bit compare enable, 1 = compare (present only with SEQ_DET_MASK_EN)
x_valid_i  input  1  serial bit qualifier
x_i  input  1  serial data bit
cnt_clr_i  input  1  synchronous clear of match counter
det_o  output  1  one-cycle detect pulse
match_cnt_o  output  CNT_W  saturating count of detections
armed_o  output  1  high once fill count >= active length

Behaviour:
- Reset values:
  - shift register, fill count, det_o, match_cnt_o, armed_o = 0
  - pattern = 0, len = 0, overlap = 1, mask = all ones
- Config:
  - On cfg_we_i, pattern/len/overlap/mask are registered.
  - The same edge clears the shift register, fill count and det_o; match_cnt_o is kept.
  - cfg_len_i > MAX_LEN is clamped to MAX_LEN.
  - cfg_len_i = 0 disables detection: det_o stays 0 and armed_o stays 0.
- Shift:
  - On each edge with x_valid_i=1, shift <= {shift[MAX_LEN-2:0], x_i}.
  - Fill count increments, saturating at MAX_LEN.
  - With x_valid_i=0, all state holds (gaps are transparent).
- Match condition, evaluated on the post-shift value:
  - For each i < len, (shift[i] ^ pattern[i]) & mask[i] == 0.
  - Fill count >= len.
  - len != 0.
- Detect timing:
  - det_o is registered.
  - It is high for exactly the one cycle following the edge that captured the completing bit. This is the same latency as the fixed detector: the bit is sampled at edge N, det_o is high between edges N and N+1.
- Overlap mode 1: shift and fill are unaffected by a match, so consecutive overlapping matches each pulse.
- Overlap mode 0: on a match, fill count is reset to 0, so the next match needs len fresh bits.
- Counter:
  - Increments on each detection and saturates at 2^CNT_W-1; it does not wrap.
  - cnt_clr_i zeroes it. If cnt_clr_i and a detection occur in the same cycle, clear wins (result 0); det_o still pulses.
- Simultaneous cfg_we_i and x_valid_i: config wins and the bit is discarded.
- armed_o = (fill count >= len) && len != 0, registered with the state.
- Reset mid-stream: all state is cleared immediately (asynchronous), and a det_o pulse in flight is dropped. After reset, the block must be reconfigured (len=0).

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - cfg_mask_i port exists and is registered on cfg_we_i.
  - Bits with mask=0 are don't-care in the compare.
- Undefined:
  - cfg_mask_i port is absent.
  - Mask is treated as all ones; every bit below len is compared.
  - No mask register is synthesised.

Test Plan:
- Fixed-word regression:
  - Stimulus: cfg pattern=12'hEDB, len=12, overlap=1; stream 0000_1110_1101_1011_0 with valid continuous.
  - Required: det_o exactly one cycle, one cycle after the final '1' is sampled; match_cnt_o=1.
- Overlap vs non-overlap:
  - Stimulus: pattern=3'b101, len=3; stream 1,0,1,0,1.
  - Required: overlap=1 gives 2 pulses and count=2; overlap=0 gives 1 pulse and count=1.
- Valid gaps:
  - Stimulus: same 12'hEDB stream with x_valid_i=0 inserted for 3 cycles between random bits.
  - Required: exactly one pulse, following the last valid bit; no pulse during gaps.
- Config/clear/saturation corners:
  - Stimulus: CNT_W=2 with 5 matches; then cnt_clr_i coincident with a match; then cfg_we_i with a partially filled shift; then len=0.
  - Required:
    - count saturates at 3.
    - clear wins (count 0, det_o=1).
    - fill restarts and armed_o=0 until len new bits.
    - len=0 gives no detections.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously, between edges, one bit before a match completes.
  - Required: all outputs 0 immediately; no pulse after release.
- Mask (SEQ_DET_MASK_EN):
  - Stimulus: pattern=4'b1001, mask=4'b1001, len=4; streams 1001, 1111, 1011.
  - Required: all three detect. Without the macro, only 1001 detects.

Source files
------------

// File: rtl/seq_detector_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_prog_if
// Purpose  : Bundles the configuration, serial-input, counter-clear and
//            result signals of the programmable serial pattern detector.
// Modports : master - drives config / serial bits / clear, observes results
//            slave  - the detector side
// Signals  : cfg_we_i       config write strobe (one cycle)
//            cfg_pattern_i  pattern, bit [len-1] oldest, bit 0 newest
//            cfg_len_i      pattern length in bits (clamped to MAX_LEN)
//            cfg_overlap_i  1 = overlapping matches allowed
//            cfg_mask_i     per-bit compare enable (SEQ_DET_MASK_EN only)
//            x_valid_i      serial bit qualifier
//            x_i            serial data bit
//            cnt_clr_i      synchronous clear of the match counter
//            det_o          one-cycle detect pulse
//            match_cnt_o    saturating detection count
//            armed_o        fill count has reached the active length
// Options  : SEQ_DET_MASK_EN adds cfg_mask_i (don't-care mask).
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
);

  logic               cfg_we_i;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               cfg_overlap_i;
`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] cfg_mask_i;
`endif
  logic               x_valid_i;
  logic               x_i;
  logic               cnt_clr_i;
  logic               det_o;
  logic [CNT_W-1:0]   match_cnt_o;
  logic               armed_o;

`ifdef SEQ_DET_MASK_EN
  modport master (
    output cfg_we_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, cfg_mask_i,
    output x_valid_i, x_i, cnt_clr_i,
    input  det_o, match_cnt_o, armed_o
  );

  modport slave (
    input  cfg_we_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, cfg_mask_i,
    input  x_valid_i, x_i, cnt_clr_i,
    output det_o, match_cnt_o, armed_o
  );
`else
  modport master (
    output cfg_we_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    output x_valid_i, x_i, cnt_clr_i,
    input  det_o, match_cnt_o, armed_o
  );

  modport slave (
    input  cfg_we_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    input  x_valid_i, x_i, cnt_clr_i,
    output det_o, match_cnt_o, armed_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_prog
// Purpose  : Runtime-programmable serial pattern (sync-word / flag) detector.
//            One bit per cycle is shifted in under x_valid_i; when the newest
//            len bits equal the programmed pattern a one-cycle det_o pulse is
//            produced and a saturating match counter advances.
// Ports    : clk    rising-edge clock
//            reset  asynchronous, active-high reset
//            bus    seq_detector_prog_if.slave (config, serial input,
//                   counter clear, det_o / match_cnt_o / armed_o)
// Params   : MAX_LEN  maximum pattern length (2..64)
//            CNT_W    match counter width
//            LEN_W    length field width (derived, do not override)
// Options  : SEQ_DET_MASK_EN - adds a per-bit don't-care mask loaded with
//            the rest of the configuration. Without it every bit below len
//            is compared and no mask register exists.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_prog #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input wire              clk,
  input wire              reset,
  seq_detector_prog_if.slave bus
);

  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [MAX_LEN-1:0] r_shift;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_fill;
  logic               r_overlap;
  logic               r_det;
  logic               r_armed;
  logic [CNT_W-1:0]   r_cnt;

  // --------------------------------------------------------------------------
  // Combinational next-state / match evaluation
  // --------------------------------------------------------------------------
  logic [MAX_LEN-1:0] w_mask_eff;
  logic [MAX_LEN-1:0] w_len_en;
  logic [MAX_LEN-1:0] w_shift_next;
  logic [MAX_LEN-1:0] w_bit_err;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_fill_upd;
  logic [LEN_W-1:0]   w_cfg_len;
  logic               w_len_nz;
  logic               w_shift_en;
  logic               w_match;

`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] r_mask;
  assign w_mask_eff = r_mask;
`else
  assign w_mask_eff = {MAX_LEN{1'b1}};
`endif

  // Only bit positions below the active length take part in the compare.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_len_en
      assign w_len_en[gi] = (LEN_W'(gi) < r_len);
    end
  endgenerate

  // A config write in the same cycle takes priority and discards the bit.
  assign w_shift_en   = bus.x_valid_i & ~bus.cfg_we_i;
  assign w_shift_next = {r_shift[MAX_LEN-2:0], bus.x_i};
  assign w_fill_next  = (r_fill == c_len_max) ? r_fill : r_fill + LEN_W'(1);
  assign w_len_nz     = (r_len != '0);
  assign w_bit_err    = (w_shift_next ^ r_pattern) & w_mask_eff & w_len_en;

  // Match is judged on the value the shift register is about to take, so
  // the registered det_o rises on the same edge that captures the last bit.
  assign w_match = w_shift_en & w_len_nz & (w_fill_next >= r_len) &
                   ~(|w_bit_err);

  // Non-overlapping mode restarts filling after a hit so the next match
  // needs a full fresh pattern's worth of bits.
  assign w_fill_upd = (w_match & ~r_overlap) ? '0 : w_fill_next;

  assign w_cfg_len = (bus.cfg_len_i > c_len_max) ? c_len_max : bus.cfg_len_i;

  // --------------------------------------------------------------------------
  // Configuration, shift register, fill count, detect and armed flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_fill    <= '0;
      r_overlap <= 1'b1;
      r_det     <= 1'b0;
      r_armed   <= 1'b0;
    end else if (bus.cfg_we_i) begin
      r_pattern <= bus.cfg_pattern_i;
      r_len     <= w_cfg_len;
      r_overlap <= bus.cfg_overlap_i;
      r_shift   <= '0;
      r_fill    <= '0;
      r_det     <= 1'b0;
      // Fill restarts at zero, so the block cannot be armed yet.
      r_armed   <= 1'b0;
    end else if (bus.x_valid_i) begin
      r_shift   <= w_shift_next;
      r_fill    <= w_fill_upd;
      r_det     <= w_match;
      r_armed   <= w_len_nz & (w_fill_upd >= r_len);
    end else begin
      // Gap cycle: everything holds except the pulse, which must end.
      r_det     <= 1'b0;
    end
  end

`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= {MAX_LEN{1'b1}};
    end else if (bus.cfg_we_i) begin
      r_mask <= bus.cfg_mask_i;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Saturating match counter. It survives config writes; a clear in the
  // same cycle as a detection wins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr_i) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.det_o       = r_det;
  assign bus.match_cnt_o = r_cnt;
  assign bus.armed_o     = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_prog
// Purpose  : Directed self-checking bench for seq_detector_prog with
//            MAX_LEN=16 and a 2-bit counter so saturation is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

`ifdef SEQ_DET_MASK_EN
  localparam logic c_mask_on = 1'b1;
`else
  localparam logic c_mask_on = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge for sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] pat, input logic [4:0] len,
                     input logic ovl, input logic [15:0] msk,
                     input logic with_bit);
    bus.cfg_we_i      = 1'b1;
    bus.cfg_pattern_i = pat;
    bus.cfg_len_i     = len;
    bus.cfg_overlap_i = ovl;
`ifdef SEQ_DET_MASK_EN
    bus.cfg_mask_i    = msk;
`endif
    bus.x_valid_i     = with_bit;
    bus.x_i           = 1'b1;
    tick();
    bus.cfg_we_i      = 1'b0;
    bus.x_valid_i     = 1'b0;
  endtask

  task automatic clr_cnt;
    bus.cnt_clr_i = 1'b1;
    tick();
    bus.cnt_clr_i = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic clr);
    bus.x_valid_i = 1'b1;
    bus.x_i       = b;
    bus.cnt_clr_i = clr;
    tick();
    bus.x_valid_i = 1'b0;
    bus.cnt_clr_i = 1'b0;
  endtask

  // Sends n bits, oldest first (bits[n-1] down to bits[0]); hist collects
  // det_o after each bit with the first bit's result in the MSB position.
  task automatic send_stream(input logic [31:0] bits, input int n,
                             output logic [31:0] hist);
    hist = '0;
    for (int k = n - 1; k >= 0; k--) begin
      send_bit(bits[k], 1'b0);
      hist = {hist[30:0], bus.det_o};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hist;
    logic        gap_det;
    logic [2:0]  mask_exp;
    logic [11:0] mask_streams;

    reset             = 1'b1;
    bus.cfg_we_i      = 1'b0;
    bus.cfg_pattern_i = '0;
    bus.cfg_len_i     = '0;
    bus.cfg_overlap_i = 1'b0;
`ifdef SEQ_DET_MASK_EN
    bus.cfg_mask_i    = '0;
`endif
    bus.x_valid_i     = 1'b0;
    bus.x_i           = 1'b0;
    bus.cnt_clr_i     = 1'b0;
    repeat (2) tick();

    // Reset state
    check_eq("rst_det",   bus.det_o,       0);
    check_eq("rst_cnt",   bus.match_cnt_o, 0);
    check_eq("rst_armed", bus.armed_o,     0);
    #2 reset = 1'b0;
    tick();

    // Fixed-word regression: 0000_1110_1101_1011_0, pulse after bit 16
    cfg(16'h0EDB, 5'd12, 1'b1, 16'hFFFF, 1'b0);
    send_stream(32'b0000_1110_1101_1011_0, 17, hist);
    check_eq("fix_hist",  hist,            32'd2);
    check_eq("fix_cnt",   bus.match_cnt_o, 1);
    check_eq("fix_armed", bus.armed_o,     1);

    // Overlap: 10101 against 101 -> hits after bits 3 and 5
    clr_cnt();
    cfg(16'h0005, 5'd3, 1'b1, 16'hFFFF, 1'b0);
    send_stream(32'b10101, 5, hist);
    check_eq("ovl1_hist", hist,            32'b00101);
    check_eq("ovl1_cnt",  bus.match_cnt_o, 2);

    // Non-overlap: only the first hit, fill restarted so not armed at end
    clr_cnt();
    cfg(16'h0005, 5'd3, 1'b0, 16'hFFFF, 1'b0);
    send_stream(32'b10101, 5, hist);
    check_eq("ovl0_hist",  hist,            32'b00100);
    check_eq("ovl0_cnt",   bus.match_cnt_o, 1);
    check_eq("ovl0_armed", bus.armed_o,     0);

    // Valid gaps: 3 idle cycles after bits 4, 10 and 14 (0-based)
    clr_cnt();
    cfg(16'h0EDB, 5'd12, 1'b1, 16'hFFFF, 1'b0);
    hist    = '0;
    gap_det = 1'b0;
    for (int k = 16; k >= 0; k--) begin
      logic [31:0] s;
      s = 32'b0000_1110_1101_1011_0;
      send_bit(s[k], 1'b0);
      hist = {hist[30:0], bus.det_o};
      if ((16 - k) == 4 || (16 - k) == 10 || (16 - k) == 14) begin
        repeat (3) begin
          tick();
          gap_det = gap_det | bus.det_o;
        end
      end
    end
    check_eq("gap_hist", hist,            32'd2);
    check_eq("gap_det",  gap_det,         0);
    check_eq("gap_cnt",  bus.match_cnt_o, 1);

    // Saturation: five overlapping hits of 101 on a 2-bit counter
    clr_cnt();
    cfg(16'h0005, 5'd3, 1'b1, 16'hFFFF, 1'b0);
    send_stream(32'b10101010101, 11, hist);
    check_eq("sat_hist", hist,            32'h155);
    check_eq("sat_cnt",  bus.match_cnt_o, 3);

    // Clear coincident with a hit: clear wins, pulse still happens
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check_eq("clrhit_det", bus.det_o,       1);
    check_eq("clrhit_cnt", bus.match_cnt_o, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("after_clr_cnt", bus.match_cnt_o, 1);

    // Config over a partially filled register, with a bit offered on the
    // config edge (must be discarded): armed only after 12 new bits
    cfg(16'h0EDB, 5'd12, 1'b1, 16'hFFFF, 1'b1);
    check_eq("recfg_armed", bus.armed_o, 0);
    check_eq("recfg_det",   bus.det_o,   0);
    check_eq("recfg_cnt",   bus.match_cnt_o, 1);
    send_stream(32'b1110_1101_101, 11, hist);
    check_eq("recfg_hist11",  hist,        0);
    check_eq("recfg_armed11", bus.armed_o, 0);
    send_bit(1'b1, 1'b0);
    check_eq("recfg_det12",   bus.det_o,   1);
    check_eq("recfg_armed12", bus.armed_o, 1);

    // Length above MAX_LEN clamps to 16
    cfg(16'hA5C3, 5'd20, 1'b1, 16'hFFFF, 1'b0);
    send_stream(32'h0000A5C3, 16, hist);
    check_eq("clamp_hist", hist, 32'd1);

    // len = 0 disables detection even with an all-zero pattern and stream
    cfg(16'h0000, 5'd0, 1'b1, 16'hFFFF, 1'b0);
    send_stream(32'h0, 20, hist);
    check_eq("len0_hist",  hist,        0);
    check_eq("len0_armed", bus.armed_o, 0);

    // Reset mid-operation while a pulse is being presented
    clr_cnt();
    cfg(16'h0005, 5'd3, 1'b1, 16'hFFFF, 1'b0);
    send_stream(32'b101, 3, hist);
    check_eq("prerst_det", bus.det_o, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_det",   bus.det_o,       0);
    check_eq("midrst_cnt",   bus.match_cnt_o, 0);
    check_eq("midrst_armed", bus.armed_o,     0);
    #2 reset = 1'b0;
    send_stream(32'b0101, 4, hist);
    check_eq("postrst_hist",  hist,        0);
    check_eq("postrst_armed", bus.armed_o, 0);

    // Mask: pattern 1001, mask 1001 -> streams 1001, 1111, 1011
    mask_streams = 12'b1001_1111_1011;
    mask_exp     = c_mask_on ? 3'b111 : 3'b100;
    for (int s = 2; s >= 0; s--) begin
      logic [3:0] str;
      str = mask_streams[s*4 +: 4];
      cfg(16'h0009, 5'd4, 1'b0, 16'h0009, 1'b0);
      send_stream({28'd0, str}, 4, hist);
      check_eq($sformatf("mask_hist_%0d", 2 - s), hist, {31'd0, mask_exp[s]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
